// File: rtl/button_event_pkg.sv
// Shared encodings and widths for the button event FSM.
package button_event_pkg;

  localparam int CNT_W   = 26;
  localparam int STATE_W = 3;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_PRESSED = 3'd1,
    ST_LONG    = 3'd2,
    ST_WAIT_DC = 3'd3,
    ST_SECOND  = 3'd4
  } state_t;

endpackage

// File: rtl/button_event_fsm.sv
// Turns a debounced button level into press/release/short/double/long/repeat
// pulses using one FSM and one shared cycle counter.
module button_event_fsm
  import button_event_pkg::*;
#(
  parameter int unsigned P_LONG_PERIOD   = 'd50_000_000,
  parameter int unsigned P_REPEAT_PERIOD = 'd10_000_000,
  parameter int unsigned P_DCLICK_PERIOD = 'd15_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_level,
  output logic               o_press,
  output logic               o_release,
  output logic               o_short,
  output logic               o_double,
  output logic               o_long,
  output logic               o_repeat,
  output logic [STATE_W-1:0] o_state
);

  if (P_LONG_PERIOD < 2 || P_LONG_PERIOD > CNT_MAX ||
      P_REPEAT_PERIOD < 2 || P_REPEAT_PERIOD > CNT_MAX ||
      P_DCLICK_PERIOD < 2 || P_DCLICK_PERIOD > CNT_MAX) begin : g_bad_period
    $error("button_event_fsm: period parameters must lie in 2..2^26-1");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(P_LONG_PERIOD - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(P_REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(P_DCLICK_PERIOD - 1);

  state_t           state;
  logic [CNT_W-1:0] r_cnt;

  assign o_state = state;

  // Level changes are tested before counter matches so they always win a tie.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_IDLE;
      r_cnt     <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_short   <= 1'b0;
      o_double  <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_short   <= 1'b0;
      o_double  <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
      case (state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (i_level) begin
            state   <= ST_PRESSED;
            o_press <= 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!i_level) begin
            state     <= ST_WAIT_DC;
            r_cnt     <= '0;
            o_release <= 1'b1;
          end else if (r_cnt == LONG_LAST) begin
            state  <= ST_LONG;
            r_cnt  <= '0;
            o_long <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_LONG: begin
          if (!i_level) begin
            state     <= ST_IDLE;
            r_cnt     <= '0;
            o_release <= 1'b1;
          end else if (r_cnt == REPEAT_LAST) begin
            r_cnt    <= '0;
            o_repeat <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_DC: begin
          if (i_level) begin
            state    <= ST_SECOND;
            r_cnt    <= '0;
            o_press  <= 1'b1;
            o_double <= 1'b1;
          end else if (r_cnt == DCLICK_LAST) begin
            state   <= ST_IDLE;
            r_cnt   <= '0;
            o_short <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SECOND: begin
          // A release here ends a double click, so no short is reported.
          if (!i_level) begin
            state     <= ST_IDLE;
            r_cnt     <= '0;
            o_release <= 1'b1;
          end else if (r_cnt == LONG_LAST) begin
            state  <= ST_LONG;
            r_cnt  <= '0;
            o_long <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_fsm.sv
// Randomized and directed bench for button_event_fsm with a timestamp-based
// event model feeding a per-cycle scoreboard.
module tb_button_event_fsm;

  localparam int LONG_P   = 8;
  localparam int REPEAT_P = 4;
  localparam int DCLICK_P = 6;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_level = 1'b0;
  logic       o_press, o_release, o_short, o_double, o_long, o_repeat;
  logic [2:0] o_state;

  button_event_fsm #(
    .P_LONG_PERIOD  (LONG_P),
    .P_REPEAT_PERIOD(REPEAT_P),
    .P_DCLICK_PERIOD(DCLICK_P)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_level  (i_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_short  (o_short),
    .o_double (o_double),
    .o_long   (o_long),
    .o_repeat (o_repeat),
    .o_state  (o_state)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [8:0] exp_q[$];

  // Event model: the button is described by when it was pressed, released,
  // and when the long threshold fired, rather than by a counter.
  int t = 0;
  bit in_press = 0, long_done = 0, second = 0, window = 0;
  int press_t = 0, rel_t = 0, long_t = 0;

  task automatic model_clear();
    in_press = 0; long_done = 0; second = 0; window = 0;
  endtask

  task automatic model_step(input logic lv, output logic [8:0] e);
    logic p, r, s, d, lg, rp;
    logic [2:0] st;
    p = 0; r = 0; s = 0; d = 0; lg = 0; rp = 0;
    t++;
    if (in_press) begin
      if (!lv) begin
        r = 1;
        in_press = 0;
        if (!long_done && !second) begin
          window = 1;
          rel_t = t;
        end
      end else if (!long_done && (t - press_t) == LONG_P) begin
        lg = 1; long_done = 1; long_t = t;
      end else if (long_done && t > long_t && ((t - long_t) % REPEAT_P) == 0) begin
        rp = 1;
      end
    end else if (window) begin
      if (lv) begin
        p = 1; d = 1; in_press = 1; second = 1; long_done = 0;
        press_t = t; window = 0;
      end else if ((t - rel_t) == DCLICK_P) begin
        s = 1; window = 0;
      end
    end else if (lv) begin
      p = 1; in_press = 1; press_t = t; second = 0; long_done = 0;
    end
    if (in_press) st = long_done ? 3'd2 : (second ? 3'd4 : 3'd1);
    else          st = window ? 3'd3 : 3'd0;
    e = {p, r, s, d, lg, rp, st};
  endtask

  task automatic drive(input logic lv, input int n);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_rst   = 1'b1;
      i_level = lv;
      model_step(lv, e);
      exp_q.push_back(e);
    end
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_rst = 1'b0;
      model_clear();
      exp_q.push_back(9'd0);
    end
  endtask

  always @(posedge i_clk) begin
    logic [8:0] e, a;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {o_press, o_release, o_short, o_double, o_long, o_repeat, o_state};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d got press,rel,short,dbl,long,rep,state=%b required=%b",
                 cyc, a, e);
      end
      checks++;
      if ($countones({o_short, o_long, o_repeat}) > 1 || (o_press && o_release)) begin
        errors++;
        $display("FAIL exclusive cyc=%0d got short,long,rep,press,rel=%b required at most one event",
                 cyc, {o_short, o_long, o_repeat, o_press, o_release});
      end
    end
  end

  initial begin
    hold_reset(3);
    drive(0, 3);
    // short click
    drive(1, 3);  drive(0, 10);
    // long hold with repeats
    drive(1, 20); drive(0, 3);
    // double click
    drive(1, 2);  drive(0, 3);  drive(1, 2);  drive(0, 10);
    // release on the long threshold
    drive(1, 8);  drive(0, 10);
    // reset during the double-click window
    drive(1, 2);  drive(0, 2);  hold_reset(2); drive(0, 10);
    // second press races the window expiry
    drive(1, 2);  drive(0, 6);  drive(1, 3);  drive(0, 10);
    // reset release while held
    hold_reset(2); drive(1, 3); drive(0, 10);
    // second press held into long
    drive(1, 2);  drive(0, 2);  drive(1, 16); drive(0, 8);
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 19) == 0) hold_reset($urandom_range(1, 3));
      drive(seg[0] ? 1'b0 : 1'b1, $urandom_range(1, 14));
    end
    drive(0, 12);
    @(posedge i_clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_fsm.md
BUTTON_EVENT_FSM -- requirements
Module: button_event_fsm

Interface
REQ-001 SHALL have parameter P_LONG_PERIOD, default 'd50_000_000, the held cycles from o_press to o_long.
REQ-002 SHALL have parameter P_REPEAT_PERIOD, default 'd10_000_000, the cycles between o_repeat pulses after o_long.
REQ-003 SHALL have parameter P_DCLICK_PERIOD, default 'd15_000_000, the double-click window in cycles after release.
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-low.
REQ-006 i_level  input  1  debounced button level, 1 = held, synchronous to i_clk; it comes from the debouncer output.
REQ-007 o_press  output  1  one-cycle pulse on each press.
REQ-008 o_release  output  1  one-cycle pulse on each release.
REQ-009 o_short  output  1  one-cycle pulse for a single short click, confirmed after the double-click window.
REQ-010 o_double  output  1  one-cycle pulse on the second press inside the window.
REQ-011 o_long  output  1  one-cycle pulse when the hold reaches P_LONG_PERIOD.
REQ-012 o_repeat  output  1  one-cycle pulse every P_REPEAT_PERIOD while held after o_long.
REQ-013 o_state  output  3  current state encoding, for debug and the 7-seg display.

Function
REQ-014 All outputs SHALL be registered; each pulse is asserted the cycle after the sampled i_level change or counter match that causes it.
REQ-015 A single 26-bit counter r_cnt SHALL be shared by all states and cleared to 0 on every state transition.
REQ-016 Each period parameter SHALL be in the range 2..2^26-1; out-of-range values are an elaboration error.
REQ-017 States: IDLE=0, PRESSED=1, LONG=2, WAIT_DC=3, SECOND=4.
REQ-018 IDLE, i_level=1: go to PRESSED and pulse o_press; otherwise stay and hold r_cnt=0.
REQ-019 PRESSED, i_level=0: go to WAIT_DC and pulse o_release.
REQ-020 PRESSED, r_cnt==P_LONG_PERIOD-1: go to LONG and pulse o_long; otherwise increment r_cnt.
REQ-021 LONG, i_level=0: go to IDLE and pulse o_release.
REQ-022 LONG, r_cnt==P_REPEAT_PERIOD-1: pulse o_repeat and set r_cnt=0; otherwise increment r_cnt.
REQ-023 WAIT_DC, i_level=1: go to SECOND and pulse o_press and o_double in the same cycle.
REQ-024 WAIT_DC, r_cnt==P_DCLICK_PERIOD-1: go to IDLE and pulse o_short; otherwise increment r_cnt.
REQ-025 SECOND, i_level=0: go to IDLE and pulse o_release; o_short SHALL NOT be pulsed.
REQ-026 SECOND, r_cnt==P_LONG_PERIOD-1: go to LONG and pulse o_long; otherwise increment r_cnt.
REQ-027 When an i_level change and a counter match occur in the same cycle, the i_level change SHALL win and the counter-match pulse SHALL NOT be emitted.
REQ-028 At most one of o_short, o_long, o_repeat SHALL be high in any cycle.
REQ-029 o_press and o_release SHALL never be high together.
REQ-030 Unused state encodings 5..7 SHALL return to IDLE on the next cycle with no pulses.

Reset
REQ-031 While i_rst=0, the block SHALL be held at state=IDLE, r_cnt=0, all pulse outputs 0, o_state=0.
REQ-032 Reset asserted mid-operation SHALL discard the pending short or double-click decision with no pulse on entry or exit.
REQ-033 After reset release with i_level=1, the block SHALL emit o_press on the first active clock.

Structure
REQ-034 Package button_event_pkg SHALL hold the state encodings, the counter width constant (26) and the o_state width.
REQ-035 The block SHALL be one flat module with one FSM and one counter; no sub-module.

Verification (parameters LONG=8, REPEAT=4, DCLICK=6; cycle k = first edge sampling the stimulus)
REQ-036 Bench SHALL check a short click: i_level high 3 cycles then low.
- Required: o_press at k+1, o_release at k+4, o_short 6 cycles later, no o_double.
REQ-037 Bench SHALL check a long hold: i_level high 20 cycles.
- Required: o_press at k+1, o_long at k+9, o_repeat at k+13 and k+17, o_release after the fall, no o_short.
REQ-038 Bench SHALL check a double click: press 2 cycles, low 3 cycles, press 2 cycles.
- Required: o_press twice, o_double with the second o_press, o_release twice, o_short never.
REQ-039 Bench SHALL check release on the threshold: in PRESSED, i_level falls in the cycle r_cnt==7.
- Required: o_release only, no o_long, state WAIT_DC.
REQ-040 Bench SHALL check reset mid-window: i_rst=0 for 2 cycles during WAIT_DC, then released with i_level=0.
- Required: all outputs 0, state IDLE, no o_short afterwards.
REQ-041 Bench SHALL check a window expiry race: second press in the same cycle as r_cnt==5 in WAIT_DC.
- Required: o_double and o_press, no o_short.
